// File: rtl/core_mem_access_if.sv
// rtl/core_mem_access_if.sv - data-memory request/ack bus between the MEM stage and the memory
interface core_mem_access_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic [7:0]  dmem_be;
  logic        dmem_ack;
  logic [63:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/core_mem_access.sv
// rtl/core_mem_access.sv - MEM stage: ALU pass-through, loads/stores over dmem with ack timeout
// Define MEM_MISALIGN_EXC_EN to trap misaligned word/dword accesses instead of aligning them down.
module core_mem_access #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ex_valid,
  input  logic [63:0]       ex_out,
  input  logic [63:0]       ex_B_data,
  input  logic [4:0]        ex_W_regnum,
  input  logic              ex_write_enable,
  input  logic [1:0]        ex_load_type,
  input  logic [1:0]        ex_store_type,
  input  logic              ex_signed_byte,
  input  logic              ex_signed_word,
  input  logic              flush,
  core_mem_access_if.master dmem,
  output logic              stall,
  output logic [63:0]       MEM_data,
  output logic [4:0]        mem_W_regnum,
  output logic              mem_write_enable,
  output logic              mem_valid,
  output logic              bus_error,
  output logic              misalign_E
);
  localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [1:0] SZ_BYTE  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

  typedef enum logic {IDLE, WAIT} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d, we_q, we_d;
  logic [63:0]   addr_q, addr_d, wdata_q, wdata_d;
  logic [7:0]    be_q, be_d;
  logic [1:0]    size_q, size_d;
  logic          sgn_b_q, sgn_b_d, sgn_w_q, sgn_w_d;
  logic [4:0]    rd_q, rd_d;
  logic          rd_we_q, rd_we_d;
  logic          flushed_q, flushed_d;
  logic [63:0]   data_q, data_d;
  logic [4:0]    mreg_q, mreg_d;
  logic          mwe_q, mwe_d, mvalid_q, mvalid_d, berr_q, berr_d, mis_q, mis_d;

  logic [1:0]    size;
  logic          is_store, misaligned, stall_c;
  logic [7:0]    rbyte;
  logic [31:0]   rword;
  logic [63:0]   ld_val;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      size_q    <= '0;
      sgn_b_q   <= 1'b0;
      sgn_w_q   <= 1'b0;
      rd_q      <= '0;
      rd_we_q   <= 1'b0;
      flushed_q <= 1'b0;
      data_q    <= '0;
      mreg_q    <= '0;
      mwe_q     <= 1'b0;
      mvalid_q  <= 1'b0;
      berr_q    <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      size_q    <= size_d;
      sgn_b_q   <= sgn_b_d;
      sgn_w_q   <= sgn_w_d;
      rd_q      <= rd_d;
      rd_we_q   <= rd_we_d;
      flushed_q <= flushed_d;
      data_q    <= data_d;
      mreg_q    <= mreg_d;
      mwe_q     <= mwe_d;
      mvalid_q  <= mvalid_d;
      berr_q    <= berr_d;
      mis_q     <= mis_d;
    end
  end

  always_comb begin
    // A store takes precedence when both load and store types are set.
    is_store = (ex_store_type != 2'd0);
    size     = is_store ? ex_store_type : ex_load_type;
`ifdef MEM_MISALIGN_EXC_EN
    misaligned = ((size == SZ_WORD) && (ex_out[1:0] != 2'b00)) ||
                 ((size == SZ_DWORD) && (ex_out[2:0] != 3'b000));
`else
    misaligned = 1'b0;
`endif
    rbyte = dmem.dmem_rdata[{addr_q[2:0], 3'b000} +: 8];
    rword = dmem.dmem_rdata[{addr_q[2], 5'b00000} +: 32];
    case (size_q)
      SZ_BYTE: ld_val = {{56{sgn_b_q & rbyte[7]}}, rbyte};
      SZ_WORD: ld_val = {{32{sgn_w_q & rword[31]}}, rword};
      default: ld_val = dmem.dmem_rdata;
    endcase

    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    size_d    = size_q;
    sgn_b_d   = sgn_b_q;
    sgn_w_d   = sgn_w_q;
    rd_d      = rd_q;
    rd_we_d   = rd_we_q;
    flushed_d = flushed_q;
    data_d    = data_q;
    mreg_d    = mreg_q;
    mwe_d     = 1'b0;
    mvalid_d  = 1'b0;
    berr_d    = 1'b0;
    mis_d     = 1'b0;
    stall_c   = 1'b0;

    case (state_q)
      IDLE: begin
        if (ex_valid && !flush) begin
          if (size == 2'd0) begin
            data_d   = ex_out;
            mreg_d   = ex_W_regnum;
            mwe_d    = ex_write_enable;
            mvalid_d = 1'b1;
          end else if (misaligned) begin
            data_d   = ex_out;
            mreg_d   = ex_W_regnum;
            mvalid_d = 1'b1;
            mis_d    = 1'b1;
          end else begin
            stall_c   = 1'b1;
            state_d   = WAIT;
            cnt_d     = '0;
            req_d     = 1'b1;
            we_d      = is_store;
            size_d    = size;
            sgn_b_d   = ex_signed_byte;
            sgn_w_d   = ex_signed_word;
            rd_d      = ex_W_regnum;
            rd_we_d   = ex_write_enable;
            flushed_d = 1'b0;
            case (size)
              SZ_BYTE: begin
                addr_d  = ex_out;
                be_d    = 8'h01 << ex_out[2:0];
                wdata_d = {8{ex_B_data[7:0]}};
              end
              SZ_WORD: begin
                addr_d  = {ex_out[63:2], 2'b00};
                be_d    = ex_out[2] ? 8'hF0 : 8'h0F;
                wdata_d = {2{ex_B_data[31:0]}};
              end
              default: begin
                addr_d  = {ex_out[63:3], 3'b000};
                be_d    = 8'hFF;
                wdata_d = ex_B_data;
              end
            endcase
          end
        end
      end
      WAIT: begin
        // A flush seen at any point in the transaction silences its completion report.
        flushed_d = flushed_q | flush;
        if (dmem.dmem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
          if (!flushed_d) begin
            mvalid_d = 1'b1;
            mreg_d   = rd_q;
            mwe_d    = rd_we_q & ~we_q;
            data_d   = we_q ? addr_q : ld_val;
          end
        end else begin
          stall_c = 1'b1;
          if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
            state_d  = IDLE;
            req_d    = 1'b0;
            berr_d   = 1'b1;
            mvalid_d = ~flushed_d;
            if (!flushed_d) mreg_d = rd_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign dmem.dmem_be    = be_q;

  assign stall            = stall_c & reset_n;
  assign MEM_data         = data_q;
  assign mem_W_regnum     = mreg_q;
  assign mem_write_enable = mwe_q;
  assign mem_valid        = mvalid_q;
  assign bus_error        = berr_q;
  assign misalign_E       = mis_q;
endmodule

// File: doc/core_mem_access.md
CORE_MEM_ACCESS -- requirements
Module: core_mem_access

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 255, meaning max cycles waiting for dmem_ack before bus error.
REQ-002 SHALL have port clock  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports ex_valid in 1 (EX result valid), ex_out in 64 (ALU result/address), ex_B_data in 64 (store data), ex_W_regnum in 5, ex_write_enable in 1.
REQ-005 SHALL have ports ex_load_type in 2 and ex_store_type in 2 (0 none, 1 byte, 2 word32, 3 dword), ex_signed_byte in 1, ex_signed_word in 1, flush in 1.
REQ-006 SHALL have memory ports dmem_req out 1, dmem_we out 1, dmem_addr out 64, dmem_wdata out 64, dmem_be out 8, dmem_ack in 1, dmem_rdata in 64.
REQ-007 SHALL have outputs stall 1 (hold upstream), MEM_data 64 (forward source), mem_W_regnum 5, mem_write_enable 1, mem_valid 1, bus_error 1, misalign_E 1.

Function
REQ-008 SHALL implement FSM states IDLE and WAIT only.
REQ-009 IDLE, ex_valid=1, no load/store, flush=0: next edge MEM_data=ex_out, mem_W_regnum/mem_write_enable copied, mem_valid=1; stall=0; one-cycle latency.
REQ-010 IDLE, ex_valid=1, load or store (store wins if both nonzero), flush=0: latch address/data/be/type, assert dmem_req (registered) next cycle, go WAIT; stall=1 combinationally this cycle.
REQ-011 WAIT: dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be SHALL hold stable until dmem_ack or timeout; stall=1 while WAIT and dmem_ack=0.
REQ-012 WAIT with dmem_ack=1: drop dmem_req next edge, register result, mem_valid=1 for one cycle, return IDLE; stall=0 that cycle.
REQ-013 dmem_be: byte 1<<addr[2:0]; word 8'h0F<<(4*addr[2]); dword 8'hFF; dmem_wdata SHALL replicate store data across lanes (byte x8, word x2).
REQ-014 Load result: byte lane addr[2:0] sign-extended if ex_signed_byte else zero-extended; word lane addr[2] sign-extended if ex_signed_word else zero-extended; dword unmodified.
REQ-015 Store completion: mem_write_enable=0, MEM_data=address.
REQ-016 Timeout counter SHALL clear on WAIT entry, increment each WAIT cycle without ack; at ACK_TIMEOUT cycles drop dmem_req, pulse bus_error with mem_valid, mem_write_enable=0, return IDLE.
REQ-017 Ack on the timeout cycle SHALL take priority over timeout.
REQ-018 flush in IDLE SHALL suppress acceptance: mem_valid=0, no request issued.
REQ-019 flush in WAIT SHALL NOT drop dmem_req; transaction completes, completion reports mem_valid=0 and mem_write_enable=0.
REQ-020 ex_valid=0 in IDLE SHALL yield mem_valid=0, mem_write_enable=0 next edge; MEM_data holds.
REQ-021 dmem_ack while IDLE SHALL be ignored.

Reset
REQ-022 reset_n=0 SHALL force IDLE, counter 0, dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr/dmem_wdata/MEM_data=0, mem_W_regnum=0, mem_write_enable=0, mem_valid=0, bus_error=0, misalign_E=0, stall=0, asynchronously.
REQ-023 Reset during WAIT SHALL abandon the transaction; no completion reported after release.

Configuration
REQ-024 With MEM_MISALIGN_EXC_EN defined: word with addr[1:0]!=0 or dword with addr[2:0]!=0 (byte never) SHALL issue no request, pulse misalign_E with mem_valid next edge, mem_write_enable=0, MEM_data=faulting address, stay IDLE.
REQ-025 Without MEM_MISALIGN_EXC_EN: address SHALL be aligned down (word clears [1:0], dword clears [2:0]) and misalign_E SHALL be tied 0.

Verification
REQ-026 ALU pass-through: ex_out=64'h1234, W_regnum=5, write_enable=1 -> next cycle MEM_data=64'h1234, mem_valid=1, stall=0.
REQ-027 Signed byte load addr 64'h1003, ack 3 cycles after req, rdata byte3=8'h80 -> dmem_be=8'h08, stall high until ack, MEM_data=64'hFFFFFFFFFFFFFF80.
REQ-028 Word store addr 64'h2004, data 64'hAABBCCDD -> dmem_we=1, dmem_be=8'hF0, dmem_wdata=64'hAABBCCDDAABBCCDD, mem_write_enable=0.
REQ-029 No ack, ACK_TIMEOUT=4 -> dmem_req high exactly 4 cycles, bus_error and mem_valid pulse once, stall released.
REQ-030 Flush asserted in WAIT during dword load -> dmem_req held until ack; completion mem_valid=0, mem_write_enable=0.
REQ-031 Word load addr 64'h3002: with MEM_MISALIGN_EXC_EN -> no dmem_req, misalign_E=1; without -> dmem_addr=64'h3000, misalign_E=0.
